// File: rtl/uart_pkg.sv
// Shared constants for the uart block: bus widths, register map, status bit
// positions and the 2-bit FSM state encoding used by both TX and RX.
package uart_pkg;

  localparam int unsigned WordAddrW = 30;
  localparam int unsigned WordDataW = 32;

  localparam logic UartAddrStatus = 1'b0;
  localparam logic UartAddrData   = 1'b1;

  localparam int unsigned StatRxValid  = 0;
  localparam int unsigned StatTxDone   = 1;
  localparam int unsigned StatTxBusy   = 2;
  localparam int unsigned StatRxBusy   = 3;
  localparam int unsigned StatOverrun  = 4;
  localparam int unsigned StatFrameErr = 5;

  typedef enum logic [1:0] {
    UartStateIdle  = 2'd0,
    UartStateStart = 2'd1,
    UartStateData  = 2'd2,
    UartStateStop  = 2'd3
  } uart_state_e;

  // Baud counter width for a given bit period.
  function automatic int unsigned uart_div_w(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, start-bit glitch rejection, mid-bit
// sampling; pulses rx_done_o for one cycle with the byte and framing status.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 217
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       rx_done_o,
  output logic [7:0] rx_data_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned DivW = uart_div_w(DIV);
  localparam logic [DivW-1:0] CntLast = DivW'(DIV - 1);
  localparam logic [DivW-1:0] CntHalf = DivW'(DIV / 2 - 1);

  uart_state_e     state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic            prev_q, prev_d;
  logic [DivW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            rx_s;

  assign rx_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[0], rx_i};
    prev_d  = rx_s;
    cnt_d   = cnt_q + DivW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
    unique case (state_q)
      UartStateIdle: begin
        cnt_d = '0;
        if (prev_q && !rx_s) state_d = UartStateStart;
      end
      UartStateStart: begin
        // Re-check the start bit at half period; a high line means a glitch.
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = rx_s ? UartStateIdle : UartStateData;
        end
      end
      UartStateData: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = UartStateStop;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      UartStateStop: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = UartStateIdle;
          done_d  = 1'b1;
          ferr_d  = ~rx_s;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= UartStateIdle;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_done_o   = done_q;
  assign rx_data_o   = shift_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != UartStateIdle);

endmodule

// File: rtl/uart.sv
// Memory-mapped 8N1 UART bus slave: STATUS/DATA registers, TX FSM, 1-cycle ack.
// Define UART_IRQ_EN to add the registered IrqRx/IrqTx level interrupts.
module uart
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 217
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic                 CS_,
  input  logic                 As_,
  input  logic                 RW,
  input  logic [WordAddrW-1:0] Addr,
  input  logic [WordDataW-1:0] WrData,
  output logic [WordDataW-1:0] RdData,
  output logic                 Rdy_,
  input  logic                 UartRX,
  output logic                 UartTX
`ifdef UART_IRQ_EN
  ,
  output logic                 IrqRx,
  output logic                 IrqTx
`endif
);

  localparam int unsigned DivW = uart_div_w(DIV);
  localparam logic [DivW-1:0] CntLast = DivW'(DIV - 1);

  logic access, rd, wr, sel_data;
  logic [WordDataW-1:0] status, w1c;

  uart_state_e     tx_state_q, tx_state_d;
  logic [DivW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d;
  logic            tx_done_set;

  logic       rx_valid_q, rx_valid_d;
  logic       tx_done_q, tx_done_d;
  logic       overrun_q, overrun_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] rx_buf_q, rx_buf_d;
  logic       rdy_n_q, rdy_n_d;
  logic [WordDataW-1:0] rd_data_q, rd_data_d;

  logic       rx_done, rx_frame_err, rx_busy, rx_ok, rx_bad;
  logic [7:0] rx_data;
  logic       unused_bits;

  assign unused_bits = ^{Addr[WordAddrW-1:1], WrData[WordDataW-1:8]};

  uart_rx #(
    .DIV(DIV)
  ) u_uart_rx (
    .clk_i      (clk),
    .rst_ni     (reset_),
    .rx_i       (UartRX),
    .rx_done_o  (rx_done),
    .rx_data_o  (rx_data),
    .frame_err_o(rx_frame_err),
    .busy_o     (rx_busy)
  );

  assign access   = ~CS_ & ~As_;
  assign rd       = access & RW;
  assign wr       = access & ~RW;
  assign sel_data = (Addr[0] == UartAddrData);
  assign rx_ok    = rx_done & ~rx_frame_err;
  assign rx_bad   = rx_done & rx_frame_err;
  assign w1c      = (wr && !sel_data) ? WrData : '0;

  always_comb begin
    status               = '0;
    status[StatRxValid]  = rx_valid_q;
    status[StatTxDone]   = tx_done_q;
    status[StatTxBusy]   = (tx_state_q != UartStateIdle);
    status[StatRxBusy]   = rx_busy;
    status[StatOverrun]  = overrun_q;
    status[StatFrameErr] = frame_err_q;
  end

  // TX FSM; tx_shift_q is shifted right so bit [1] is always the next data bit.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q + DivW'(1);
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_d        = tx_q;
    tx_done_set = 1'b0;
    unique case (tx_state_q)
      UartStateIdle: begin
        tx_cnt_d = '0;
        if (wr && sel_data) begin
          tx_state_d = UartStateStart;
          tx_shift_d = WrData[7:0];
          tx_d       = 1'b0;
        end
      end
      UartStateStart: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_state_d = UartStateData;
          tx_d       = tx_shift_q[0];
        end
      end
      UartStateData: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = UartStateStop;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end
      end
      UartStateStop: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d    = '0;
          tx_state_d  = UartStateIdle;
          tx_done_set = 1'b1;
        end
      end
    endcase
  end

  // Register file: sets are applied after clears so a same-edge set wins.
  always_comb begin
    rx_valid_d = rx_valid_q;
    if (rd && sel_data) rx_valid_d = 1'b0;
    if (rx_ok)          rx_valid_d = 1'b1;

    rx_buf_d = rx_ok ? rx_data : rx_buf_q;

    overrun_d = overrun_q & ~w1c[StatOverrun];
    if (rx_ok && rx_valid_q) overrun_d = 1'b1;

    frame_err_d = frame_err_q & ~w1c[StatFrameErr];
    if (rx_bad) frame_err_d = 1'b1;

    tx_done_d = tx_done_q & ~w1c[StatTxDone];
    if (tx_done_set) tx_done_d = 1'b1;

    rdy_n_d   = ~access;
    rd_data_d = '0;
    if (rd) rd_data_d = sel_data ? {{(WordDataW - 8){1'b0}}, rx_buf_q} : status;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      tx_state_q  <= UartStateIdle;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'h00;
      tx_q        <= 1'b1;
      rx_valid_q  <= 1'b0;
      tx_done_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_buf_q    <= 8'h00;
      rdy_n_q     <= 1'b1;
      rd_data_q   <= '0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
      rx_valid_q  <= rx_valid_d;
      tx_done_q   <= tx_done_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rx_buf_q    <= rx_buf_d;
      rdy_n_q     <= rdy_n_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign UartTX = tx_q;
  assign Rdy_   = rdy_n_q;
  assign RdData = rd_data_q;

`ifdef UART_IRQ_EN
  logic irq_rx_q, irq_tx_q;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      irq_rx_q <= 1'b0;
      irq_tx_q <= 1'b0;
    end else begin
      irq_rx_q <= rx_valid_q | overrun_q | frame_err_q;
      irq_tx_q <= tx_done_q;
    end
  end

  assign IrqRx = irq_rx_q;
  assign IrqTx = irq_tx_q;
`endif

endmodule

// File: tb/tb_uart.sv
// Scoreboard bench for uart with DIV=8: bus accesses push the expected RdData,
// a negedge monitor pops and compares on every acknowledge.
module tb_uart;

  localparam int unsigned Div = 8;

  logic        clk;
  logic        reset_;
  logic        CS_, As_, RW;
  logic [29:0] Addr;
  logic [31:0] WrData;
  logic [31:0] RdData;
  logic        Rdy_;
  logic        UartRX;
  logic        UartTX;
`ifdef UART_IRQ_EN
  logic        IrqRx, IrqTx;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  uart #(
    .DIV(Div)
  ) dut (
    .clk   (clk),
    .reset_(reset_),
    .CS_   (CS_),
    .As_   (As_),
    .RW    (RW),
    .Addr  (Addr),
    .WrData(WrData),
    .RdData(RdData),
    .Rdy_  (Rdy_),
    .UartRX(UartRX),
    .UartTX(UartTX)
`ifdef UART_IRQ_EN
    ,
    .IrqRx (IrqRx),
    .IrqTx (IrqTx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every ack must match the oldest expected value; idle RdData must be 0.
  always @(negedge clk) begin
    if (reset_) begin
      total++;
      if (!Rdy_) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ack: got RdData=0x%0h expected no ack", RdData);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (RdData !== e) begin
            bad++;
            $display("FAIL ack_data: got 0x%0h expected 0x%0h", RdData, e);
          end
        end
      end else if (RdData !== 32'h0) begin
        bad++;
        $display("FAIL idle_rddata: got 0x%0h expected 0x0", RdData);
      end
    end
  end

  task automatic bus_acc(input logic rw, input logic a0, input logic [31:0] wd,
                         input logic [31:0] exp);
    @(posedge clk); #1;
    CS_ = 1'b0; As_ = 1'b0; RW = rw; Addr = {29'b0, a0}; WrData = wd;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    CS_ = 1'b1; As_ = 1'b1; RW = 1'b1;
    @(negedge clk); #1;
    chk("ack_latency_pending", exp_q.size(), 0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    @(posedge clk); #1;
    for (int b = 0; b < 10; b++) begin
      UartRX = bits[b];
      repeat (Div) @(posedge clk);
      #1;
    end
    UartRX = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  logic [9:0] txbits;

  initial begin
    reset_ = 1'b0; CS_ = 1'b1; As_ = 1'b1; RW = 1'b1;
    Addr = '0; WrData = '0; UartRX = 1'b1;
    repeat (3) @(posedge clk);
    chk("reset_rdy", Rdy_, 1);
    chk("reset_rddata", RdData, 0);
    chk("reset_uarttx", UartTX, 1);
    #1 reset_ = 1'b1;

    bus_acc(1'b1, 1'b0, 0, 32'h00);

    // TX 0xA5: start, LSB-first data, stop; first sample cycle consumed by bus_acc.
    txbits = {1'b1, 8'hA5, 1'b0};
    bus_acc(1'b0, 1'b1, 32'hA5, 32'h0);
    fork
      begin
        for (int i = 1; i < 10 * Div; i++) begin
          @(negedge clk);
          chk($sformatf("tx_bit%0d", i / Div), UartTX, txbits[i / Div]);
        end
      end
      begin
        repeat (20) @(posedge clk);
        bus_acc(1'b1, 1'b0, 0, 32'h04);
        bus_acc(1'b0, 1'b1, 32'h5A, 32'h0);
        repeat (30) @(posedge clk);
        bus_acc(1'b1, 1'b0, 0, 32'h04);
      end
    join
    bus_acc(1'b1, 1'b0, 0, 32'h02);
`ifdef UART_IRQ_EN
    chk("irq_tx", IrqTx, 1);
`endif
    chk("tx_idle_high", UartTX, 1);
    bus_acc(1'b0, 1'b0, 32'h2, 32'h0);
    bus_acc(1'b1, 1'b0, 0, 32'h00);

    // RX 0x3C
    send_frame(8'h3C, 1'b1);
    bus_acc(1'b1, 1'b0, 0, 32'h01);
`ifdef UART_IRQ_EN
    chk("irq_rx_set", IrqRx, 1);
`endif
    bus_acc(1'b1, 1'b1, 0, 32'h3C);
`ifdef UART_IRQ_EN
    @(posedge clk); #1;
    chk("irq_rx_clr", IrqRx, 0);
`endif
    bus_acc(1'b1, 1'b0, 0, 32'h00);

    // Overrun: two frames, no read in between
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    bus_acc(1'b1, 1'b0, 0, 32'h11);
    bus_acc(1'b1, 1'b1, 0, 32'h22);
    bus_acc(1'b1, 1'b0, 0, 32'h10);
    bus_acc(1'b0, 1'b0, 32'h10, 32'h0);
    bus_acc(1'b1, 1'b0, 0, 32'h00);

    // Framing error leaves buffer and RX_VALID alone
    send_frame(8'h55, 1'b0);
    bus_acc(1'b1, 1'b0, 0, 32'h20);
    bus_acc(1'b1, 1'b1, 0, 32'h22);
    bus_acc(1'b0, 1'b0, 32'h20, 32'h0);
    bus_acc(1'b1, 1'b0, 0, 32'h00);

    // 2-cycle glitch is rejected
    @(posedge clk); #1;
    UartRX = 1'b0;
    repeat (2) @(posedge clk);
    #1 UartRX = 1'b1;
    repeat (20) @(posedge clk);
    bus_acc(1'b1, 1'b0, 0, 32'h00);

    // Reset mid-TX
    bus_acc(1'b0, 1'b1, 32'h00, 32'h0);
    repeat (20) @(posedge clk);
    chk("midtx_low", UartTX, 0);
    #3 reset_ = 1'b0;
    #1;
    chk("reset_async_tx", UartTX, 1);
    chk("reset_async_rdy", Rdy_, 1);
    @(posedge clk); #1 reset_ = 1'b1;
    bus_acc(1'b1, 1'b0, 0, 32'h00);
    bus_acc(1'b1, 1'b1, 0, 32'h00);

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
